// File: rtl/pix_capture_ctrl_pkg.sv
// Shared definitions for the pixel capture controller: RAMController command
// codes, FSM state encoding and helpers for frame/counter sizing.
package pix_capture_ctrl_pkg;

  // RAMController command codes driven on ramctrl_cmd
  localparam logic [1:0] RAMController_Cmd_None  = 2'd0;
  localparam logic [1:0] RAMController_Cmd_Write = 2'd1;

  // Capture FSM states; Idle is encoded 0 so a reset debug view reads all zero
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CMD        = 3'd1,
    ST_WAIT_READY = 3'd2,
    ST_ARM        = 3'd3,
    ST_COPY       = 3'd4,
    ST_TAIL       = 3'd5
  } state_t;

  // Words in one frame
  function automatic int frame_words(input int width, input int height);
    return width * height;
  endfunction

  // Register width able to hold values 0..max_val inclusive
  function automatic int reg_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pix_capture_ctrl_if.sv
// FIFO read port plus RAMController write port seen by the capture controller.
// Handshakes:
//   FIFO  : a word is popped on a clock edge where fifo_rok && fifo_rtrigger.
//   RAM   : a word is written on a clock edge where ramctrl_write_trigger &&
//           ramctrl_write_ready; trigger and data hold until that edge.
//   ramctrl_write_done is a 1-cycle pulse when the RAM block is finished.
interface pix_capture_ctrl_if #(
  parameter int DataWidth = 16
) ();

  logic                 fifo_rok;
  logic [DataWidth-1:0] fifo_rdata;
  logic                 fifo_rtrigger;
  logic [1:0]           ramctrl_cmd;
  logic [2:0]           ramctrl_cmd_block;
  logic                 ramctrl_write_ready;
  logic                 ramctrl_write_trigger;
  logic [DataWidth-1:0] ramctrl_write_data;
  logic                 ramctrl_write_done;

  // Controller side
  modport master (
    input  fifo_rok, fifo_rdata, ramctrl_write_ready, ramctrl_write_done,
    output fifo_rtrigger, ramctrl_cmd, ramctrl_cmd_block,
           ramctrl_write_trigger, ramctrl_write_data
  );

  // FIFO / RAMController side
  modport slave (
    output fifo_rok, fifo_rdata, ramctrl_write_ready, ramctrl_write_done,
    input  fifo_rtrigger, ramctrl_cmd, ramctrl_cmd_block,
           ramctrl_write_trigger, ramctrl_write_data
  );

endinterface

// File: rtl/pix_capture_ctrl_stats.sv
// Running sum/max of popped pixel words. The running values restart when a
// frame is armed; the published copy is refreshed once per completed frame.
module pix_capture_stats #(
  parameter int DataWidth = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear_i,
  input  logic                 pop_i,
  input  logic [DataWidth-1:0] data_i,
  input  logic                 publish_i,
  output logic [39:0]          stat_sum_o,
  output logic [DataWidth-1:0] stat_max_o
);

  logic [39:0]          sum_q, sum_d;
  logic [DataWidth-1:0] max_q, max_d;
  logic [39:0]          pub_sum_q;
  logic [DataWidth-1:0] pub_max_q;

  // Next running values: clear on arm, accumulate on every pop
  always_comb begin
    sum_d = sum_q;
    max_d = max_q;
    if (clear_i) begin
      sum_d = '0;
      max_d = '0;
    end else if (pop_i) begin
      sum_d = sum_q + 40'(data_i);
      if (data_i > max_q) max_d = data_i;
    end
  end

  // Running accumulators and published copy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum_q     <= '0;
      max_q     <= '0;
      pub_sum_q <= '0;
      pub_max_q <= '0;
    end else begin
      sum_q <= sum_d;
      max_q <= max_d;
      if (publish_i) begin
        pub_sum_q <= sum_q;
        pub_max_q <= max_q;
      end
    end
  end

  assign stat_sum_o = pub_sum_q;
  assign stat_max_o = pub_max_q;

endmodule

// File: rtl/pix_capture_ctrl.sv
// Pixel capture controller: copies FIFO words into a RAMController block, one
// frame per block, single-shot or as a continuous ring of blocks. Counts words
// per frame and flags short frames and words arriving after the frame ends.
// Optional build macro PIX_CAPTURE_STATS_EN adds stat_sum/stat_max outputs.
module pix_capture_ctrl
  import pix_capture_ctrl_pkg::*;
#(
  parameter int DataWidth   = 16,
  parameter int ImageWidth  = 2304,
  parameter int ImageHeight = 1296,
  parameter int BlockCount  = 8,
  parameter int TailCycles  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_trigger,
  input  logic                 cmd_mode,
  input  logic [2:0]           cmd_block,
  input  logic                 cmd_stop,
  output logic                 capture_start,
  pix_capture_ctrl_if.master   bus,
  output logic                 busy,
  output logic                 frame_done,
  output logic [2:0]           frame_block,
  output logic                 err_short,
  output logic                 err_extra,
  output state_t               dbg_state
`ifdef PIX_CAPTURE_STATS_EN
  ,
  output logic [39:0]          stat_sum,
  output logic [DataWidth-1:0] stat_max
`endif
);

  localparam int FrameWords = frame_words(ImageWidth, ImageHeight);
  localparam int RegWidth   = reg_width(FrameWords);
  localparam int TailWidth  = reg_width(TailCycles);

  localparam logic [RegWidth-1:0]  FrameCnt = RegWidth'(FrameWords);
  localparam logic [TailWidth-1:0] TailLast = TailWidth'(TailCycles - 1);
  localparam logic [2:0]           BlockWrap = 3'(BlockCount);

  state_t               state_q, state_d;
  logic                 mode_q, mode_d;
  logic [2:0]           block_q, block_d;
  logic                 stop_q, stop_d;
  logic                 busy_q, busy_d;
  logic                 cap_q, cap_d;
  logic                 wr_trig_q, wr_trig_d;
  logic [DataWidth-1:0] wr_data_q, wr_data_d;
  logic [RegWidth-1:0]  count_q, count_d;
  logic [TailWidth-1:0] tail_q, tail_d;
  logic                 fdone_q, fdone_d;
  logic [2:0]           fblock_q, fblock_d;
  logic                 err_short_q, err_short_d;
  logic                 err_extra_q, err_extra_d;

  logic [1:0]           cmd_c;
  logic                 rtrig_c;
  logic [2:0]           blk_inc;
  logic [2:0]           blk_next;

  // Next ring block, wrapping at BlockCount in 3-bit arithmetic
  always_comb begin
    blk_inc  = block_q + 3'd1;
    blk_next = (blk_inc == BlockWrap) ? 3'd0 : blk_inc;
  end

  // FSM next state, datapath next values and combinational outputs
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    block_d     = block_q;
    stop_d      = stop_q;
    busy_d      = busy_q;
    cap_d       = cap_q;
    wr_trig_d   = wr_trig_q;
    wr_data_d   = wr_data_q;
    count_d     = count_q;
    tail_d      = tail_q;
    fdone_d     = 1'b0;
    fblock_d    = fblock_q;
    err_short_d = err_short_q;
    err_extra_d = err_extra_q;
    cmd_c       = RAMController_Cmd_None;
    rtrig_c     = 1'b0;

    // A stop request only matters for a running continuous capture
    if (busy_q && mode_q && cmd_stop) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (cmd_trigger) begin
          mode_d      = cmd_mode;
          block_d     = cmd_block;
          stop_d      = 1'b0;
          err_short_d = 1'b0;
          err_extra_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = ST_CMD;
        end
      end
      ST_CMD: begin
        cmd_c   = RAMController_Cmd_Write;
        state_d = ST_WAIT_READY;
      end
      ST_WAIT_READY: begin
        if (bus.ramctrl_write_ready) state_d = ST_ARM;
      end
      ST_ARM: begin
        cap_d   = ~cap_q;
        count_d = '0;
        state_d = ST_COPY;
      end
      ST_COPY: begin
        if (bus.ramctrl_write_done) begin
          // The block is closed: nothing is popped in this cycle, so any word
          // showing up now is left in the FIFO for the tail check.
          fdone_d   = 1'b1;
          fblock_d  = block_q;
          wr_trig_d = 1'b0;
          tail_d    = '0;
          if (count_q < FrameCnt) err_short_d = 1'b1;
          state_d   = ST_TAIL;
        end else begin
          rtrig_c = !wr_trig_q || bus.ramctrl_write_ready;
          if (bus.fifo_rok && rtrig_c) begin
            wr_data_d = bus.fifo_rdata;
            wr_trig_d = 1'b1;
            if (count_q != FrameCnt) count_d = count_q + RegWidth'(1);
          end else if (wr_trig_q && bus.ramctrl_write_ready) begin
            wr_trig_d = 1'b0;
          end
        end
      end
      ST_TAIL: begin
        if (bus.fifo_rok) err_extra_d = 1'b1;
        if (tail_q == TailLast) begin
          if (mode_q && !stop_q) begin
            block_d = blk_next;
            state_d = ST_CMD;
          end else begin
            busy_d  = 1'b0;
            stop_d  = 1'b0;
            state_d = ST_IDLE;
          end
        end else begin
          tail_d = tail_q + TailWidth'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= 1'b0;
      block_q     <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      cap_q       <= 1'b0;
      wr_trig_q   <= 1'b0;
      wr_data_q   <= '0;
      count_q     <= '0;
      tail_q      <= '0;
      fdone_q     <= 1'b0;
      fblock_q    <= '0;
      err_short_q <= 1'b0;
      err_extra_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      block_q     <= block_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      cap_q       <= cap_d;
      wr_trig_q   <= wr_trig_d;
      wr_data_q   <= wr_data_d;
      count_q     <= count_d;
      tail_q      <= tail_d;
      fdone_q     <= fdone_d;
      fblock_q    <= fblock_d;
      err_short_q <= err_short_d;
      err_extra_q <= err_extra_d;
    end
  end

  assign bus.fifo_rtrigger         = rtrig_c;
  assign bus.ramctrl_cmd           = cmd_c;
  assign bus.ramctrl_cmd_block     = block_q;
  assign bus.ramctrl_write_trigger = wr_trig_q;
  assign bus.ramctrl_write_data    = wr_data_q;

  assign capture_start = cap_q;
  assign busy          = busy_q;
  assign frame_done    = fdone_q;
  assign frame_block   = fblock_q;
  assign err_short     = err_short_q;
  assign err_extra     = err_extra_q;
  assign dbg_state     = state_q;

`ifdef PIX_CAPTURE_STATS_EN
  logic pop_c;
  assign pop_c = bus.fifo_rok && rtrig_c;

  pix_capture_stats #(
    .DataWidth (DataWidth)
  ) u_stats (
    .clk        (clk),
    .rst        (rst),
    .clear_i    (state_q == ST_ARM),
    .pop_i      (pop_c),
    .data_i     (bus.fifo_rdata),
    .publish_i  (fdone_q),
    .stat_sum_o (stat_sum),
    .stat_max_o (stat_max)
  );
`endif

endmodule
